// File: rtl/writeback_arbiter.sv
// Two-entry result queue: registered head, count and wrapping pointers.
// Latency: an entry pushed at edge T is visible at head_dat after edge T.
// Backpressure: a push when count==2 is dropped; the owner gates with count.
module wb_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic             tail;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != 2'd2);
    assign do_pop   = pop && (count != 2'd0);
    assign head_dat = mem[head];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_dat;
                tail      <= ~tail;
            end
            if (do_pop)
                head <= ~head;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Three-source writeback arbiter: alu/lsu/br queues round-robin onto one CDB.
// Latency: a beat accepted at edge T into an idle path is on cdb_* after edge T+1.
// Backpressure: s_ready drops while that source's queue holds 2 entries or flush is high.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 5,
    parameter int QDEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [PREG_WIDTH-1:0] alu_dest,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [ROB_WIDTH-1:0]  alu_rob_tag,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [PREG_WIDTH-1:0] lsu_dest,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic [ROB_WIDTH-1:0]  lsu_rob_tag,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [PREG_WIDTH-1:0] br_dest,
    input  logic [DATA_WIDTH-1:0] br_data,
    input  logic [ROB_WIDTH-1:0]  br_rob_tag,
    output logic                  cdb_valid,
    output logic [PREG_WIDTH-1:0] cdb_dest,
    output logic [DATA_WIDTH-1:0] cdb_data,
    output logic [ROB_WIDTH-1:0]  cdb_rob_tag
);
    typedef struct packed {
        logic [PREG_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] data;
        logic [ROB_WIDTH-1:0]  rob_tag;
    } entry_t;

    localparam logic [1:0] FULL = 2'(QDEPTH);

    logic [2:0] src_vld;
    logic [2:0] src_rdy;
    logic [2:0] push;
    logic [2:0] pop;
    logic [2:0] nonempty;
    entry_t     src_dat  [3];
    entry_t     head_dat [3];
    logic [1:0] cnt      [3];

    logic [1:0] rr_ptr;
    logic [1:0] ord0, ord1, ord2;
    logic [1:0] winner;
    logic       grant_vld;
    entry_t     win_dat;

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign src_vld    = {br_valid, lsu_valid, alu_valid};
    assign src_dat[0] = {alu_dest, alu_data, alu_rob_tag};
    assign src_dat[1] = {lsu_dest, lsu_data, lsu_rob_tag};
    assign src_dat[2] = {br_dest, br_data, br_rob_tag};

    for (genvar s = 0; s < 3; s++) begin : g_src
        assign src_rdy[s]  = (cnt[s] != FULL) && !flush;
        assign push[s]     = src_vld[s] && src_rdy[s];
        assign nonempty[s] = (cnt[s] != 2'd0);

        wb_fifo #(.WIDTH($bits(entry_t))) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .clear    (flush),
            .push     (push[s]),
            .push_dat (src_dat[s]),
            .pop      (pop[s]),
            .head_dat (head_dat[s]),
            .count    (cnt[s])
        );
    end

    assign alu_ready = src_rdy[0];
    assign lsu_ready = src_rdy[1];
    assign br_ready  = src_rdy[2];

    // Search order starts at rr_ptr and wraps 2 -> 0.
    always_comb begin
        ord0      = rr_ptr;
        ord1      = rr_next(ord0);
        ord2      = rr_next(ord1);
        grant_vld = 1'b1;
        winner    = rr_ptr;
        if (nonempty[ord0])      winner = ord0;
        else if (nonempty[ord1]) winner = ord1;
        else if (nonempty[ord2]) winner = ord2;
        else                     grant_vld = 1'b0;

        case (winner)
            2'd0:    win_dat = head_dat[0];
            2'd1:    win_dat = head_dat[1];
            default: win_dat = head_dat[2];
        endcase

        pop = (grant_vld && !flush) ? (3'b001 << winner) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= 2'd0;
            cdb_valid   <= 1'b0;
            cdb_dest    <= '0;
            cdb_data    <= '0;
            cdb_rob_tag <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant_vld) begin
            cdb_valid   <= 1'b1;
            cdb_dest    <= win_dat.dest;
            cdb_data    <= win_dat.data;
            cdb_rob_tag <= win_dat.rob_tag;
            rr_ptr      <= rr_next(winner);
        end else begin
            cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model plus directed literal checks.
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        v   [3];
    logic [6:0]  d   [3];
    logic [31:0] dat [3];
    logic [4:0]  tg  [3];
    logic        alu_ready, lsu_ready, br_ready;
    logic        cdb_valid;
    logic [6:0]  cdb_dest;
    logic [31:0] cdb_data;
    logic [4:0]  cdb_rob_tag;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alu_valid   (v[0]),
        .alu_ready   (alu_ready),
        .alu_dest    (d[0]),
        .alu_data    (dat[0]),
        .alu_rob_tag (tg[0]),
        .lsu_valid   (v[1]),
        .lsu_ready   (lsu_ready),
        .lsu_dest    (d[1]),
        .lsu_data    (dat[1]),
        .lsu_rob_tag (tg[1]),
        .br_valid    (v[2]),
        .br_ready    (br_ready),
        .br_dest     (d[2]),
        .br_data     (dat[2]),
        .br_rob_tag  (tg[2]),
        .cdb_valid   (cdb_valid),
        .cdb_dest    (cdb_dest),
        .cdb_data    (cdb_data),
        .cdb_rob_tag (cdb_rob_tag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [6:0]  dest;
        logic [31:0] data;
        logic [4:0]  tag;
    } ent_t;

    ent_t        mq [3][$];
    int          rr = 0;
    bit          started = 0;
    bit          known = 0;
    logic        ev;
    logic [6:0]  ed;
    logic [31:0] edat;
    logic [4:0]  et;

    always @(posedge clk) begin
        logic r, f;
        logic pv [3];
        ent_t pe [3];
        bit   pr [3];
        ent_t e;
        int   w;
        logic [2:0] rdy;
        r = reset;
        f = flush;
        for (int s = 0; s < 3; s++) begin
            pv[s] = v[s];
            pe[s] = '{d[s], dat[s], tg[s]};
            pr[s] = (mq[s].size() < 2) && !f;
        end
        if (r) begin
            for (int s = 0; s < 3; s++) mq[s].delete();
            rr = 0; ev = 0; ed = 0; edat = 0; et = 0;
            known = 1; started = 1;
        end else if (f) begin
            for (int s = 0; s < 3; s++) mq[s].delete();
            ev = 0; known = 0;
        end else begin
            w = -1;
            for (int k = 0; k < 3; k++)
                if (w < 0 && mq[(rr + k) % 3].size() > 0) w = (rr + k) % 3;
            if (w >= 0) begin
                e = mq[w].pop_front();
                ev = 1; ed = e.dest; edat = e.data; et = e.tag;
                known = 1;
                rr = (w + 1) % 3;
            end else begin
                ev = 0;
            end
            for (int s = 0; s < 3; s++)
                if (pv[s] && pr[s]) mq[s].push_back(pe[s]);
        end
        #1;
        if (started) begin
            chk("model_cdb_valid", {31'd0, cdb_valid}, {31'd0, ev});
            if (known) begin
                chk("model_cdb_dest", {25'd0, cdb_dest}, {25'd0, ed});
                chk("model_cdb_data", cdb_data, edat);
                chk("model_cdb_rob_tag", {27'd0, cdb_rob_tag}, {27'd0, et});
            end
            rdy = {br_ready, lsu_ready, alu_ready};
            for (int s = 0; s < 3; s++)
                chk($sformatf("model_ready%0d", s), {31'd0, rdy[s]},
                    {31'd0, (mq[s].size() < 2) && !flush});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_src();
        for (int s = 0; s < 3; s++) begin
            v[s] = 0; d[s] = 0; dat[s] = 0; tg[s] = 0;
        end
    endtask

    task automatic set_src(input int s, input logic [6:0] dd, input logic [31:0] da, input logic [4:0] tt);
        v[s] = 1; d[s] = dd; dat[s] = da; tg[s] = tt;
    endtask

    initial begin
        logic [6:0] got [$];
        bit   seen_full;
        bit   hs;
        int   idx;
        logic [6:0] g;

        reset = 1; flush = 0;
        clear_src();
        step(); step();
        chk("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("reset_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("reset_br_ready", {31'd0, br_ready}, 32'd1);
        chk("reset_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("reset_cdb_dest", {25'd0, cdb_dest}, 32'd0);
        chk("reset_cdb_data", cdb_data, 32'd0);
        chk("reset_cdb_rob_tag", {27'd0, cdb_rob_tag}, 32'd0);
        reset = 0;

        // all three sources in one cycle after reset: alu, lsu, br in turn
        set_src(0, 7'd1, 32'h11, 5'd1);
        set_src(1, 7'd2, 32'h22, 5'd2);
        set_src(2, 7'd3, 32'h33, 5'd3);
        step(); clear_src();
        step(); chk("rr_first_dest", {25'd0, cdb_dest}, 32'd1);
        chk("rr_first_valid", {31'd0, cdb_valid}, 32'd1);
        step(); chk("rr_second_dest", {25'd0, cdb_dest}, 32'd2);
        step(); chk("rr_third_dest", {25'd0, cdb_dest}, 32'd3);
        step(); chk("rr_idle_valid", {31'd0, cdb_valid}, 32'd0);

        // single alu beat, two-edge latency, one-cycle pulse
        set_src(0, 7'd5, 32'hDEADBEEF, 5'd3);
        step(); clear_src();
        step();
        chk("single_valid", {31'd0, cdb_valid}, 32'd1);
        chk("single_dest", {25'd0, cdb_dest}, 32'd5);
        chk("single_data", cdb_data, 32'hDEADBEEF);
        chk("single_rob_tag", {27'd0, cdb_rob_tag}, 32'd3);
        step();
        chk("single_after_valid", {31'd0, cdb_valid}, 32'd0);
        chk("single_hold_data", cdb_data, 32'hDEADBEEF);

        // dest 0 is broadcast as-is
        set_src(2, 7'd0, 32'h1234, 5'd9);
        step(); clear_src();
        step();
        chk("p0_valid", {31'd0, cdb_valid}, 32'd1);
        chk("p0_dest", {25'd0, cdb_dest}, 32'd0);
        chk("p0_data", cdb_data, 32'h1234);

        // lsu backpressure with alu/br streaming
        seen_full = 0; idx = 0;
        for (int i = 0; i < 40 && got.size() < 3; i++) begin
            set_src(0, 7'(64 + i % 32), $urandom, 5'(i));
            set_src(2, 7'(96 + i % 32), $urandom, 5'(i));
            if (idx < 3) set_src(1, 7'(10 + idx), 32'(idx), 5'(idx));
            else v[1] = 0;
            hs = v[1] && lsu_ready;
            if (!lsu_ready) seen_full = 1;
            step();
            if (hs) idx++;
            if (cdb_valid && cdb_dest >= 7'd10 && cdb_dest <= 7'd12) got.push_back(cdb_dest);
        end
        chk("lsu_ready_dropped", {31'd0, seen_full}, 32'd1);
        chk("lsu_bcast_count", got.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            g = (k < got.size()) ? got[k] : 7'h7F;
            chk($sformatf("lsu_order%0d", k), {25'd0, g}, 32'(10 + k));
        end
        clear_src();
        for (int i = 0; i < 6; i++) step();

        // fill every queue, then flush
        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < 3; s++) set_src(s, 7'(40 + s), 32'hF00 + 32'(s), 5'(s));
            step();
        end
        flush = 1;
        for (int s = 0; s < 3; s++) set_src(s, 7'(100 + s), 32'hBAD, 5'd0);
        step();
        chk("flush_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("flush_lsu_ready_low", {31'd0, lsu_ready}, 32'd0);
        flush = 0; clear_src();
        #1;
        chk("postflush_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("postflush_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("postflush_br_ready", {31'd0, br_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("postflush_quiet%0d", i), {31'd0, cdb_valid}, 32'd0);
        end

        // reset while queues are loaded
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 3; s++) set_src(s, 7'(50 + s), 32'hAB, 5'(s));
            step();
        end
        reset = 1;
        step();
        chk("midreset_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("midreset_cdb_dest", {25'd0, cdb_dest}, 32'd0);
        reset = 0; clear_src();
        step();
        chk("midreset_after_valid", {31'd0, cdb_valid}, 32'd0);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 150) == 0;
            flush = ($urandom % 40) == 0;
            for (int s = 0; s < 3; s++) begin
                v[s]   = ($urandom % 100) < 60;
                d[s]   = 7'($urandom);
                dat[s] = $urandom;
                tg[s]  = 5'($urandom);
            end
            step();
        end
        reset = 0; flush = 0; clear_src();
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
